// File: rtl/r_type_if.sv
// R-type execute unit bus: issue side (valid, instruction word, operands) and
// registered result side (result, valid, illegal qualifier).
interface r_type_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic [XLEN-1:0] out;
  logic            out_valid;
  logic            illegal;

  modport master (
    output in_valid, instr, in1, in2,
    input  out, out_valid, illegal
  );

  modport slave (
    input  in_valid, instr, in1, in2,
    output out, out_valid, illegal
  );
endinterface

// File: rtl/r_type.sv
// RV32I R-type execute unit: decodes {instr[30], instr[14:12]} and registers the result.
// Optional RV32M multiply/divide via `define R_TYPE_MEXT_EN (selected by instr[25]).
module r_type #(
  parameter int unsigned XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  r_type_if.slave    bus
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b1000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b1101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111
  } op_e;

  logic [3:0]         w_key;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_base_result;
  logic               w_base_illegal;
  logic [XLEN-1:0]    w_result;
  logic               w_illegal;

  logic [XLEN-1:0]    r_out;
  logic               r_out_valid;
  logic               r_illegal;

  assign w_key   = {bus.instr[30], bus.instr[14:12]};
  assign w_shamt = bus.in2[SHAMT_W-1:0];

  // Base integer operations
  always_comb begin
    w_base_result  = '0;
    w_base_illegal = 1'b0;
    case (w_key)
      OP_ADD:  w_base_result = bus.in1 + bus.in2;
      OP_SUB:  w_base_result = bus.in1 - bus.in2;
      OP_SLL:  w_base_result = bus.in1 << w_shamt;
      OP_SLT:  w_base_result = XLEN'($signed(bus.in1) < $signed(bus.in2));
      OP_SLTU: w_base_result = XLEN'(bus.in1 < bus.in2);
      OP_XOR:  w_base_result = bus.in1 ^ bus.in2;
      OP_SRL:  w_base_result = bus.in1 >> w_shamt;
      OP_SRA:  w_base_result = $unsigned($signed(bus.in1) >>> w_shamt);
      OP_OR:   w_base_result = bus.in1 | bus.in2;
      OP_AND:  w_base_result = bus.in1 & bus.in2;
      default: w_base_illegal = 1'b1;
    endcase
  end

`ifdef R_TYPE_MEXT_EN
  logic [2*XLEN-1:0] w_a_s;
  logic [2*XLEN-1:0] w_a_u;
  logic [2*XLEN-1:0] w_b_s;
  logic [2*XLEN-1:0] w_b_u;
  logic [2*XLEN-1:0] w_prod_ss;
  logic [2*XLEN-1:0] w_prod_su;
  logic [2*XLEN-1:0] w_prod_uu;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic [XLEN-1:0]   w_dsor;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_quo_u;
  logic [XLEN-1:0]   w_rem_u;
  logic [XLEN-1:0]   w_m_result;
  logic              w_unused_ok;

  // Sign/zero-extended operands; low 2*XLEN bits of each product hold the exact high word
  assign w_a_s     = {{XLEN{bus.in1[XLEN-1]}}, bus.in1};
  assign w_a_u     = {{XLEN{1'b0}}, bus.in1};
  assign w_b_s     = {{XLEN{bus.in2[XLEN-1]}}, bus.in2};
  assign w_b_u     = {{XLEN{1'b0}}, bus.in2};
  assign w_prod_ss = w_a_s * w_b_s;
  assign w_prod_su = w_a_s * w_b_u;
  assign w_prod_uu = w_a_u * w_b_u;

  // Corner cases are patched after the divider, so feed it a harmless divisor there
  assign w_div_zero = (bus.in2 == '0);
  assign w_div_ovf  = (bus.in1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in2 == '1);
  assign w_dsor     = (w_div_zero || w_div_ovf) ? XLEN'(1) : bus.in2;
  assign w_quo_s    = $unsigned($signed(bus.in1) / $signed(w_dsor));
  assign w_rem_s    = $unsigned($signed(bus.in1) % $signed(w_dsor));
  assign w_quo_u    = bus.in1 / w_dsor;
  assign w_rem_u    = bus.in1 % w_dsor;

  always_comb begin
    w_m_result = '0;
    case (bus.instr[14:12])
      3'b000:  w_m_result = w_prod_uu[XLEN-1:0];
      3'b001:  w_m_result = w_prod_ss[2*XLEN-1:XLEN];
      3'b010:  w_m_result = w_prod_su[2*XLEN-1:XLEN];
      3'b011:  w_m_result = w_prod_uu[2*XLEN-1:XLEN];
      3'b100:  w_m_result = w_div_zero ? '1 : (w_div_ovf ? bus.in1 : w_quo_s);
      3'b101:  w_m_result = w_div_zero ? '1 : w_quo_u;
      3'b110:  w_m_result = w_div_zero ? bus.in1 : (w_div_ovf ? '0 : w_rem_s);
      default: w_m_result = w_div_zero ? bus.in1 : w_rem_u;
    endcase
  end

  // instr[25] routes to the M table; combined with instr[30] it is not an encoding
  always_comb begin
    w_result  = w_base_result;
    w_illegal = w_base_illegal;
    if (bus.instr[25]) begin
      if (bus.instr[30]) begin
        w_result  = '0;
        w_illegal = 1'b1;
      end else begin
        w_result  = w_m_result;
        w_illegal = 1'b0;
      end
    end
  end

  assign w_unused_ok = ^{bus.instr[31], bus.instr[29:26], bus.instr[24:15], bus.instr[11:0]};
`else
  logic w_unused_ok;

  always_comb begin
    w_result  = w_base_result;
    w_illegal = w_base_illegal;
  end

  assign w_unused_ok = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:0]};
`endif

  // Result register: out holds across idle cycles, qualifiers drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (bus.in_valid) begin
      r_out       <= w_result;
      r_out_valid <= 1'b1;
      r_illegal   <= w_illegal;
    end else begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_r_type.sv
// Directed-vector bench for r_type; expected values are hand-computed constants.
module tb_r_type;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  r_type_if #(.XLEN(32)) bus ();

  r_type #(.XLEN(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive one op, then step to #1 after the capturing edge
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.in1      = a;
    bus.in2      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.instr    = 32'h0;
    bus.in1      = 32'hDEAD_BEEF;
    bus.in2      = 32'h1234_5678;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input string tag, input logic [31:0] exp, input logic ill);
    check({tag, ".out"}, bus.out, exp);
    check({tag, ".vld"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".ill"}, 32'(bus.illegal), 32'(ill));
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr    = 32'h0;
    bus.in1      = 32'd5;
    bus.in2      = 32'd7;

    repeat (2) @(posedge clk);
    #1;
    check("rst.out", bus.out, 32'd0);
    check("rst.vld", 32'(bus.out_valid), 32'd0);
    check("rst.ill", 32'(bus.illegal), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_res("rst_rel", 32'd12, 1'b0);

    issue(32'h0000_0000, 32'd415, 32'd60);        expect_res("add", 32'd475, 1'b0);
    issue(32'h4000_0000, 32'd6553, 32'd653);      expect_res("sub", 32'd5900, 1'b0);
    issue(32'h4000_0000, 32'd0, 32'd1);           expect_res("sub_wrap", 32'hFFFF_FFFF, 1'b0);
    issue(32'h0000_0000, 32'hFFFF_FFFF, 32'd1);   expect_res("add_wrap", 32'd0, 1'b0);
    issue(32'h00B5_0533, 32'd3, 32'd4);           expect_res("add_flds", 32'd7, 1'b0);
    issue(32'h0000_1000, 32'd288, 32'd349);       expect_res("sll", 32'd0, 1'b0);
    issue(32'h0000_1000, 32'd3, 32'hFFFF_FFE4);   expect_res("sll_hi", 32'd48, 1'b0);
    issue(32'h0000_5000, 32'h8000_0000, 32'd4);   expect_res("srl", 32'h0800_0000, 1'b0);
    issue(32'h4000_5000, 32'h8000_0000, 32'd4);   expect_res("sra", 32'hF800_0000, 1'b0);
    issue(32'h4000_5000, 32'h7000_0000, 32'd36);  expect_res("sra_pos", 32'h0700_0000, 1'b0);
    issue(32'h4000_5000, 32'h8000_0000, 32'd31);  expect_res("sra_31", 32'hFFFF_FFFF, 1'b0);
    issue(32'h0000_2000, 32'hFFFF_FFFF, 32'd1);   expect_res("slt_neg", 32'd1, 1'b0);
    issue(32'h0000_3000, 32'hFFFF_FFFF, 32'd1);   expect_res("sltu_big", 32'd0, 1'b0);
    issue(32'h0000_3000, 32'd447, 32'd726);       expect_res("sltu", 32'd1, 1'b0);
    issue(32'h0000_2000, 32'd696, 32'd623);       expect_res("slt", 32'd0, 1'b0);
    issue(32'h0000_4000, 32'd696, 32'd939);       expect_res("xor", 32'd275, 1'b0);
    issue(32'h0000_6000, 32'd378, 32'd960);       expect_res("or", 32'd1018, 1'b0);
    issue(32'h0000_7000, 32'd404, 32'd900);       expect_res("and", 32'd388, 1'b0);

    // Every undefined key, each preceded by a nonzero result so the zero is visible
    for (int k = 0; k < 6; k++) begin
      logic [31:0] ill_ins [6];
      ill_ins = '{32'h4000_1000, 32'h4000_2000, 32'h4000_3000,
                  32'h4000_4000, 32'h4000_6000, 32'h4000_7000};
      issue(32'h0000_6000, 32'd5, 32'd2);         expect_res("pre_ill", 32'd7, 1'b0);
      issue(ill_ins[k], 32'd5, 32'd2);            expect_res($sformatf("ill%0d", k), 32'd0, 1'b1);
    end

    idle();
    check("idle.out", bus.out, 32'd0);
    check("idle.vld", 32'(bus.out_valid), 32'd0);
    check("idle.ill", 32'(bus.illegal), 32'd0);

    issue(32'h0000_0000, 32'd100, 32'd23);        expect_res("add2", 32'd123, 1'b0);
    idle();
    check("hold.out", bus.out, 32'd123);
    check("hold.vld", 32'(bus.out_valid), 32'd0);
    idle();
    check("hold2.out", bus.out, 32'd123);

`ifdef R_TYPE_MEXT_EN
    issue(32'h0200_0000, 32'd6, 32'd7);           expect_res("mul", 32'd42, 1'b0);
    issue(32'h0200_4000, 32'd7, 32'd0);           expect_res("div0", 32'hFFFF_FFFF, 1'b0);
    issue(32'h0200_5000, 32'd7, 32'd0);           expect_res("divu0", 32'hFFFF_FFFF, 1'b0);
    issue(32'h0200_6000, 32'd7, 32'd0);           expect_res("rem0", 32'd7, 1'b0);
    issue(32'h0200_7000, 32'd9, 32'd0);           expect_res("remu0", 32'd9, 1'b0);
    issue(32'h0200_4000, 32'h8000_0000, 32'hFFFF_FFFF); expect_res("div_ovf", 32'h8000_0000, 1'b0);
    issue(32'h0200_6000, 32'h8000_0000, 32'hFFFF_FFFF); expect_res("rem_ovf", 32'd0, 1'b0);
    issue(32'h0200_4000, 32'hFFFF_FFF9, 32'd2);   expect_res("div_neg", 32'hFFFF_FFFD, 1'b0);
    issue(32'h0200_6000, 32'hFFFF_FFF9, 32'd2);   expect_res("rem_neg", 32'hFFFF_FFFF, 1'b0);
    issue(32'h0200_5000, 32'hFFFF_FFF9, 32'd2);   expect_res("divu", 32'h7FFF_FFFC, 1'b0);
    issue(32'h0200_7000, 32'd17, 32'd5);          expect_res("remu", 32'd2, 1'b0);
    issue(32'h0200_1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF); expect_res("mulh", 32'd0, 1'b0);
    issue(32'h0200_2000, 32'hFFFF_FFFF, 32'hFFFF_FFFF); expect_res("mulhsu", 32'hFFFF_FFFF, 1'b0);
    issue(32'h0200_3000, 32'hFFFF_FFFF, 32'hFFFF_FFFF); expect_res("mulhu", 32'hFFFF_FFFE, 1'b0);
    issue(32'h4200_0000, 32'd6, 32'd7);           expect_res("m_ill", 32'd0, 1'b1);
`else
    issue(32'h0200_0000, 32'd6, 32'd7);           expect_res("b25_add", 32'd13, 1'b0);
    issue(32'h4200_0000, 32'd6, 32'd7);           expect_res("b25_sub", 32'hFFFF_FFFF, 1'b0);
    issue(32'h0200_4000, 32'd7, 32'd0);           expect_res("b25_xor", 32'd7, 1'b0);
`endif

    // Asynchronous reset between edges drops the registered result at once
    issue(32'h0000_0000, 32'd40, 32'd2);          expect_res("pre_rst", 32'd42, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out", bus.out, 32'd0);
    check("arst.vld", 32'(bus.out_valid), 32'd0);
    check("arst.ill", 32'(bus.illegal), 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold.out", bus.out, 32'd0);
    rst_n = 1'b1;
    issue(32'h0000_7000, 32'hFF00_FF00, 32'h0F0F_0F0F); expect_res("post_rst", 32'h0F00_0F00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/r_type.md
Name: r_type

Overview:
RV32I R-type execute unit for the single-cycle datapath. Decodes funct7[5]/funct3 straight from the instruction word and applies the selected operation to two 32-bit register operands. The result is registered, giving one cycle of latency, with a valid/illegal qualifier. It sits between the register-file read ports and the writeback mux.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and instr are valid this cycle
instr  input  32  full instruction word; bits [30], [14:12] decoded (plus [25] with optional feature)
in1  input  32  rs1 value
in2  input  32  rs2 value
out  output  32  registered result
out_valid  output  1  out holds the result of the op issued on the previous cycle
illegal  output  1  registered flag: the previous issued op had an unsupported encoding

Behaviour:
- Reset (rst_n low, asynchronous): out=0, out_valid=0, illegal=0. All three stay there until the first rising edge after release.
- Opcode bits [6:0], rd, rs1 and rs2 fields are ignored. The caller guarantees the word is R-type.
- Decode key is {instr[30], instr[14:12]}. Other funct7 bits are ignored, except bit 25 when the optional feature is compiled in.
  - 0000 ADD: in1+in2, modulo 2^32
  - 1000 SUB: in1-in2, modulo 2^32
  - 0001 SLL: in1 << in2[4:0]
  - 0010 SLT: 1 if signed(in1) < signed(in2), else 0
  - 0011 SLTU: 1 if unsigned(in1) < unsigned(in2), else 0
  - 0100 XOR: in1 ^ in2
  - 0101 SRL: logical in1 >> in2[4:0]
  - 1101 SRA: arithmetic in1 >>> in2[4:0], sign bit replicated
  - 0110 OR: in1 | in2
  - 0111 AND: in1 & in2
  - Any other key (1001, 1010, 1011, 1100, 1110, 1111): result 0, illegal=1.
- Shift amounts use only in2[4:0]; in2[31:5] is ignored.
- No overflow or carry flags; ADD and SUB wrap.
- Timing: on a rising edge with in_valid=1, out takes the result and out_valid=1. illegal takes the decode flag.
- On a rising edge with in_valid=0: out holds its previous value, out_valid=0, illegal=0.
- Back-to-back issue every cycle is supported; there is no stall and no backpressure.
- rst_n asserted mid-operation discards the in-flight result immediately.

Optional Feature:
R_TYPE_MEXT_EN
- Defined:
  - instr[25]=1 with instr[30]=0 selects RV32M by funct3: 000 MUL (low 32), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Divide by zero: DIV/DIVU=0xFFFFFFFF, REM/REMU=in1.
  - Signed overflow (0x80000000 / -1): DIV=0x80000000, REM=0.
  - instr[25]=1 with instr[30]=1: illegal=1, result 0.
  - Same one-cycle registered latency; the multiply/divide is combinational.
- Undefined: instr[25] is ignored. Only the RV32I table applies and no multiply/divide logic is synthesized.

Test Plan:
- Reset: hold rst_n=0, apply in_valid=1, instr=0, in1=5, in2=7 -> out=0, out_valid=0, illegal=0. Release, next edge -> out=12, out_valid=1.
- Arithmetic, issued back-to-back:
  - instr=0x00000000, in1=415, in2=60 -> out=475
  - instr=0x40000000, in1=6553, in2=653 -> out=5900 (one cycle later)
  - instr=0x40000000, in1=0, in2=1 -> out=0xFFFFFFFF
- Shifts:
  - SLL instr=0x00001000, in1=288, in2=349 (shamt 29) -> out=0
  - SRL instr=0x00005000, in1=0x80000000, in2=4 -> 0x08000000
  - SRA instr=0x40005000, same operands -> 0xF8000000
- Compares/logic:
  - SLT (0x2000) in1=0xFFFFFFFF, in2=1 -> 1
  - SLTU (0x3000) same operands -> 0
  - SLTU in1=447, in2=726 -> 1
  - SLT in1=696, in2=623 -> 0
  - XOR (0x4000) in1=696, in2=939 -> 275
  - OR (0x6000) in1=378, in2=960 -> 1018
  - AND (0x7000) in1=404, in2=900 -> 388
- Illegal/idle:
  - instr=0x40001000 -> out=0, illegal=1, out_valid=1
  - Next cycle in_valid=0 -> out_valid=0, illegal=0, out holds 0.
- With R_TYPE_MEXT_EN:
  - instr=0x02004000 (DIV), in1=7, in2=0 -> 0xFFFFFFFF
  - instr=0x02000000 (MUL), in1=6, in2=7 -> 42
